task_10_output: RTL and testbench
=================================

// Module: task_10_output
// PURPOSE
//  Transmit end of the task_10 datapath. Collects processed bytes from the core (i_wr strobe) into a sync FIFO.
//  On i_frame_end, streams the whole frame out as an AXI-Stream master (tvalid/tready/tlast).
//  Counterpart to task_10_input: frame in over AXI-S, bytes into core, core bytes back out over AXI-S.
// PARAMETERS
//  DATA_W   8    byte width of i_data / o_tdata
//  DEPTH    256  FIFO depth = max frame length in bytes (power of 2)
//  CNT_W    $clog2(DEPTH+1)  localparam, width of frame byte counter
// PORTS
//  i_clk          in   1       clock
//  i_rst          in   1       reset, synchronous, active-high
//  i_data         in   DATA_W  byte from core
//  i_wr           in   1       i_data valid this cycle
//  i_frame_end    in   1       frame complete pulse (may coincide with last i_wr)
//  o_ready_in     out  1       block accepts i_wr (high only in s_COLLECT)
//  i_tready       in   1       downstream ready
//  o_tdata_valid  out  1       AXI-S tvalid
//  o_tdata        out  DATA_W  AXI-S tdata
//  o_tdata_last   out  1       AXI-S tlast, high with final byte of frame
//  o_busy         out  1       frame in progress (collect with >=1 byte, or send)
//  o_empty        out  1       FIFO empty
//  o_overflow     out  1       sticky: byte dropped (i_wr while !o_ready_in or FIFO full)
// BEHAVIOUR
//  Reset values: o_tdata_valid=0, o_tdata=0, o_tdata_last=0, o_busy=0, o_ready_in=0, o_overflow=0, o_empty=1.
//  Reset also clears the FIFO via sclr, the counters and the skid buffer.
//  States (registered, next-state comb): s_IDLE -> s_COLLECT -> s_SEND -> s_DONE -> s_IDLE.
//   s_IDLE: byte counter cleared; always goes to s_COLLECT next cycle.
//   s_COLLECT: i_wr && !full writes i_data and increments cnt.
//    i_frame_end with (cnt + same-cycle write) > 0 -> s_SEND.
//    i_frame_end with zero bytes is ignored and the state stays s_COLLECT.
//   s_SEND: rem := cnt loaded on entry; rdreq issued while rem_to_read>0 and the skid has room.
//    FIFO q has 1-cycle read latency and feeds a 2-entry output skid buffer.
//   s_DONE: entered on the handshake of the tlast byte; o_busy drops here; one cycle, then s_IDLE.
//  Latency: i_frame_end in cycle N -> o_tdata_valid first high in cycle N+2.
//  Throughput: 1 byte/cycle sustained while i_tready=1; no bubbles after the first byte.
//  Handshake: a byte transfers when o_tdata_valid && i_tready.
//   Once valid rises, o_tdata and o_tdata_last hold until that handshake; valid never drops without one.
//  o_tdata_last=1 exactly on the byte where the remaining-to-send count == 1. A 1-byte frame has last on its only byte.
//  Overflow: i_wr while full or outside s_COLLECT drops the byte and sets o_overflow.
//   The dropped byte is not counted; o_overflow clears only on i_rst.
//  Full: at cnt==DEPTH, further writes are dropped; an i_frame_end still sends DEPTH bytes.
//  o_busy: rises on the first accepted byte; falls in the cycle after the tlast handshake.
//  i_tready low indefinitely: the block holds its state; no timeout.
//  i_rst mid-frame: next edge -> s_IDLE, valid=0, FIFO flushed, frame discarded.
// STRUCTURE
//  task_10_pkg: state enum task_output_enum {s_IDLE,s_COLLECT,s_SEND,s_DONE}, DATA_W default constant.
//  Sub-module task_10_output_fifo: sync FIFO; clock, sclr, data, wrreq, rdreq, q (registered), empty, full, usedw.
//  Top holds the FSM, counters, 2-entry skid and overflow flag.
// TESTING
//  1 Write 0x11,0x22,0x33 + frame_end, tready=1 -> valid at N+2; bytes 11,22,33 on consecutive cycles; last only on 33.
//  2 Same frame, tready toggling 1,0,0,1,... -> no byte lost or duplicated; tdata/tlast stable while valid && !tready.
//  3 Single byte 0xA5 with i_frame_end in the same cycle -> one transfer, tdata=A5, tlast=1; then s_IDLE, o_busy=0.
//  4 DEPTH+2 writes then frame_end -> o_overflow=1; exactly DEPTH bytes sent; last on byte DEPTH.
//  5 frame_end with no bytes -> no valid, state stays s_COLLECT; i_wr during s_SEND -> dropped, o_overflow=1.
//  6 i_rst after 2 of 5 bytes sent -> valid=0 next cycle, o_empty=1; fresh 2-byte frame then sends correctly.

Source files
------------

// File: rtl/task_10_pkg.sv
// task_10_pkg: shared types and defaults for the task_10 output path.
//  task_output_enum : FSM states of task_10_output
//  DATA_W_DEF       : default byte width
//  DEPTH_DEF        : default FIFO depth (max frame length in bytes)
package task_10_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    s_IDLE,
    s_COLLECT,
    s_SEND,
    s_DONE
  } task_output_enum;
endpackage

// File: rtl/task_10_output_fifo.sv
// task_10_output_fifo: synchronous FIFO with registered read data.
//  i_clk    : clock
//  i_sclr   : synchronous clear (pointers, occupancy, q)
//  i_data   : write data
//  i_wrreq  : write request (ignored when full)
//  i_rdreq  : read request (ignored when empty); o_q valid the next cycle
//  o_q      : registered read data
//  o_empty  : no entries
//  o_full   : DEPTH entries
//  o_usedw  : occupancy, 0..DEPTH
module task_10_output_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_sclr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wrreq,
  input  logic              i_rdreq,
  output logic [DATA_W-1:0] o_q,
  output logic              o_empty,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_usedw
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_q;
  logic              w_wr, w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_usedw = r_cnt;
  assign o_q     = r_q;
  assign w_wr    = i_wrreq && !o_full;
  assign w_rd    = i_rdreq && !o_empty;

  // Storage has no reset; pointers alone define contents.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_sclr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
        r_q    <= r_mem[r_rptr];
      end
      r_cnt <= r_cnt + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end
endmodule

// File: rtl/task_10_output.sv
// task_10_output: collects core bytes into a FIFO and, on frame end, streams
// the whole frame out as an AXI-Stream master.
//  i_clk, i_rst        : clock, synchronous active-high reset
//  i_data, i_wr        : byte from core and its strobe
//  i_frame_end         : frame complete (may coincide with the last i_wr)
//  o_ready_in          : bytes accepted (collect state only)
//  i_tready            : downstream ready
//  o_tdata_valid/o_tdata/o_tdata_last : AXI-S master
//  o_busy              : frame in progress
//  o_empty             : FIFO empty
//  o_overflow          : sticky, a byte was dropped
module task_10_output
  import task_10_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_wr,
  input  logic              i_frame_end,
  output logic              o_ready_in,
  input  logic              i_tready,
  output logic              o_tdata_valid,
  output logic [DATA_W-1:0] o_tdata,
  output logic              o_tdata_last,
  output logic              o_busy,
  output logic              o_empty,
  output logic              o_overflow
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  task_output_enum               r_state, w_next;
  logic [CNT_W-1:0]              r_cnt, r_rem_rd, r_rem_tx, w_cnt_tot, w_usedw;
  logic                          r_ready_in, r_busy, r_ovf, r_q_vld;
  logic [1:0][DATA_W-1:0]        r_skid;
  logic [1:0]                    r_skid_cnt;
  logic [DATA_W-1:0]             w_q;
  logic                          w_full, w_empty, w_acc, w_room, w_rdreq, w_pop;

  task_10_output_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_sclr  (i_rst),
    .i_data  (i_data),
    .i_wrreq (w_acc),
    .i_rdreq (w_rdreq),
    .o_q     (w_q),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_usedw (w_usedw)
  );

  assign w_acc     = i_wr && (r_state == s_COLLECT) && !w_full;
  assign w_cnt_tot = r_cnt + CNT_W'(w_acc);

  // Output queue = skid entries followed by the FIFO q in flight. Reads are
  // issued only while fewer than two bytes are held, so the skid never
  // overflows and i_tready has no combinational path to the FIFO.
  assign w_room  = (r_skid_cnt == 2'd0) || ((r_skid_cnt == 2'd1) && !r_q_vld);
  assign w_rdreq = (r_state == s_SEND) && (r_rem_rd != '0) && w_room && !w_empty;

  assign o_tdata_valid = (r_skid_cnt != 2'd0) || r_q_vld;
  assign o_tdata       = (r_skid_cnt != 2'd0) ? r_skid[0] : w_q;
  assign o_tdata_last  = o_tdata_valid && (r_rem_tx == CNT_W'(1));
  assign w_pop         = o_tdata_valid && i_tready;

  assign o_ready_in = r_ready_in;
  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;
  assign o_empty    = (w_usedw == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      s_IDLE:    w_next = s_COLLECT;
      s_COLLECT: if (i_frame_end && (w_cnt_tot != '0)) w_next = s_SEND;
      s_SEND:    if (w_pop && (r_rem_tx == CNT_W'(1))) w_next = s_DONE;
      default:   w_next = s_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= s_IDLE;
      r_cnt      <= '0;
      r_rem_rd   <= '0;
      r_rem_tx   <= '0;
      r_ready_in <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_q_vld    <= 1'b0;
      r_skid     <= '0;
      r_skid_cnt <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_ready_in <= (w_next == s_COLLECT);
      r_busy     <= (w_next == s_SEND) ||
                    ((w_next == s_COLLECT) && (r_state == s_COLLECT) && (w_cnt_tot != '0));
      if (i_wr && !w_acc) r_ovf <= 1'b1;

      if (r_state == s_IDLE) r_cnt <= '0;
      else if (w_acc)        r_cnt <= r_cnt + 1'b1;

      if ((r_state == s_COLLECT) && (w_next == s_SEND)) begin
        r_rem_rd <= w_cnt_tot;
        r_rem_tx <= w_cnt_tot;
      end else begin
        if (w_rdreq) r_rem_rd <= r_rem_rd - 1'b1;
        if (w_pop)   r_rem_tx <= r_rem_tx - 1'b1;
      end

      r_q_vld <= w_rdreq;
      // Any held byte not popped this cycle ends up in the skid, in order.
      case (r_skid_cnt)
        2'd0: if (r_q_vld && !w_pop) begin
          r_skid[0]  <= w_q;
          r_skid_cnt <= 2'd1;
        end
        2'd1: if (w_pop) begin
          if (r_q_vld) r_skid[0] <= w_q;
          else         r_skid_cnt <= 2'd0;
        end else if (r_q_vld) begin
          r_skid[1]  <= w_q;
          r_skid_cnt <= 2'd2;
        end
        default: if (w_pop) begin
          r_skid[0]  <= r_skid[1];
          r_skid_cnt <= 2'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_task_10_output.sv
module tb_task_10_output;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          i_clk = 1'b0;
  logic          i_rst, i_wr, i_frame_end;
  logic [DW-1:0] i_data;
  logic          i_tready = 1'b1;
  logic          o_ready_in, o_tdata_valid, o_tdata_last, o_busy, o_empty, o_overflow;
  logic [DW-1:0] o_tdata;

  task_10_output #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_wr(i_wr),
    .i_frame_end(i_frame_end), .o_ready_in(o_ready_in), .i_tready(i_tready),
    .o_tdata_valid(o_tdata_valid), .o_tdata(o_tdata), .o_tdata_last(o_tdata_last),
    .o_busy(o_busy), .o_empty(o_empty), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of expected {last,data} in transfer order.
  logic [8:0] exp_q[$];
  logic [7:0] frm[$];
  bit         exp_ovf = 0;
  int         n_hs = 0;

  // Downstream ready patterns: 0 always, 1 random, 2 held low, 3 1,0,0 repeating.
  int tr_mode = 0, tr_ph = 0;
  always @(posedge i_clk) begin
    #1;
    tr_ph++;
    case (tr_mode)
      0:       i_tready = 1'b1;
      1:       i_tready = 1'($urandom_range(0, 1));
      2:       i_tready = 1'b0;
      default: i_tready = (tr_ph % 3 == 0);
    endcase
  end

  // Output monitor: every handshake must match the model; a stalled beat must hold.
  bit         stall = 0;
  logic [7:0] st_d;
  logic       st_l;
  always @(negedge i_clk) begin
    if (i_rst) stall = 0;
    else begin
      if (stall) begin
        check("hold_valid", o_tdata_valid, 1);
        check("hold_data", o_tdata, st_d);
        check("hold_last", o_tdata_last, st_l);
      end
      if (o_tdata_valid && i_tready) begin
        n_hs++;
        check("expected_byte_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("tx_data", o_tdata, e[7:0]);
          check("tx_last", o_tdata_last, e[8]);
        end
      end
      stall = o_tdata_valid && !i_tready;
      st_d  = o_tdata;
      st_l  = o_tdata_last;
    end
  end

  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  task automatic chk_reset_vals();
    check("rst_valid", o_tdata_valid, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_last", o_tdata_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", o_ready_in, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_empty", o_empty, 1);
  endtask

  task automatic do_reset();
    i_rst = 1; i_wr = 0; i_frame_end = 0;
    exp_q.delete();
    exp_ovf = 0;
    cyc();
    chk_reset_vals();
    cyc();
    i_rst = 0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!o_ready_in && k < 100) begin cyc(); k++; end
    check("ready_timeout", o_ready_in, 1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || o_busy) && k < 3000) begin cyc(); k++; end
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", o_busy, 0);
  endtask

  // Writes frm; frame_end either with the last byte or one cycle later.
  // Returns in the cycle after the frame_end cycle.
  task automatic send_frame(input bit fe_same, input bit gaps);
    int n   = frm.size();
    int acc = (n < DEPTH) ? n : DEPTH;
    if (n > DEPTH) exp_ovf = 1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        i_wr = 0; i_frame_end = 0; cyc();
      end
      i_wr = 1; i_data = frm[i];
      i_frame_end = fe_same && (i == n - 1);
      if (i < acc) exp_q.push_back({(i == acc - 1), frm[i]});
      cyc();
    end
    i_wr = 0;
    if (!fe_same) begin i_frame_end = 1; cyc(); end
    i_frame_end = 0;
  endtask

  initial begin
    int h0, k, len;
    i_data = 0;
    do_reset();

    // 1: three bytes, latency N+2, back-to-back, last on the third
    tr_mode = 0;
    wait_ready();
    frm = '{8'h11, 8'h22, 8'h33};
    send_frame(0, 0);
    check("t1_n1_valid", o_tdata_valid, 0);
    cyc();
    check("t1_n2_valid", o_tdata_valid, 1);
    check("t1_d0", o_tdata, 8'h11);
    check("t1_l0", o_tdata_last, 0);
    check("t1_busy", o_busy, 1);
    cyc();
    check("t1_d1", o_tdata, 8'h22);
    check("t1_v1", o_tdata_valid, 1);
    cyc();
    check("t1_d2", o_tdata, 8'h33);
    check("t1_l2", o_tdata_last, 1);
    cyc();
    check("t1_done_valid", o_tdata_valid, 0);
    check("t1_done_busy", o_busy, 0);
    check("t1_done_ready", o_ready_in, 0);
    wait_drain();

    // 2: same frame with ready toggling
    tr_mode = 3;
    wait_ready();
    h0 = n_hs;
    frm = '{8'h11, 8'h22, 8'h33};
    send_frame(0, 0);
    wait_drain();
    check("t2_count", n_hs - h0, 3);

    // 3: single byte with frame_end in the same cycle
    tr_mode = 0;
    wait_ready();
    h0 = n_hs;
    frm = '{8'hA5};
    send_frame(1, 0);
    check("t3_n1_valid", o_tdata_valid, 0);
    cyc();
    check("t3_valid", o_tdata_valid, 1);
    check("t3_data", o_tdata, 8'hA5);
    check("t3_last", o_tdata_last, 1);
    cyc();
    check("t3_busy", o_busy, 0);
    check("t3_valid_after", o_tdata_valid, 0);
    cyc(); cyc();
    check("t3_back_collect", o_ready_in, 1);
    check("t3_count", n_hs - h0, 1);

    // 5a: frame_end with nothing collected is ignored
    wait_ready();
    i_frame_end = 1; cyc(); i_frame_end = 0;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_valid", o_tdata_valid, 0);
      check("t5_collect", o_ready_in, 1);
      cyc();
    end
    check("t5_no_ovf", o_overflow, 0);
    // 5b: write during send is dropped and flagged
    tr_mode = 2;
    h0 = n_hs;
    frm = '{8'h01, 8'h02, 8'h03};
    send_frame(0, 0);
    i_wr = 1; i_data = 8'h77; cyc(); i_wr = 0;
    cyc();
    check("t5_ovf", o_overflow, 1);
    tr_mode = 0;
    wait_drain();
    check("t5_count", n_hs - h0, 3);

    do_reset();

    // 4: DEPTH+2 writes, only DEPTH sent, last on byte DEPTH
    tr_mode = 1;
    wait_ready();
    h0 = n_hs;
    frm.delete();
    for (int i = 0; i < DEPTH + 2; i++) frm.push_back(8'($urandom));
    send_frame(0, 0);
    check("t4_ovf", o_overflow, 1);
    wait_drain();
    check("t4_count", n_hs - h0, DEPTH);

    // 6: reset after two of five bytes, then a fresh frame
    do_reset();
    tr_mode = 0;
    wait_ready();
    h0 = n_hs;
    frm = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    send_frame(0, 0);
    k = 0;
    while (n_hs - h0 < 2 && k < 50) begin cyc(); k++; end
    check("t6_two_sent", n_hs - h0, 2);
    i_rst = 1; exp_q.delete();
    cyc();
    i_rst = 0;
    check("t6_valid", o_tdata_valid, 0);
    check("t6_empty", o_empty, 1);
    check("t6_busy", o_busy, 0);
    wait_ready();
    h0 = n_hs;
    frm = '{8'hC1, 8'hC2};
    send_frame(0, 0);
    wait_drain();
    check("t6_count", n_hs - h0, 2);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 2))
        0: tr_mode = 0;
        1: tr_mode = 1;
        default: tr_mode = 3;
      endcase
      wait_ready();
      h0 = n_hs;
      len = $urandom_range(1, DEPTH + 2);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      send_frame(1'($urandom_range(0, 1)), 1);
      check("rnd_ovf", o_overflow, exp_ovf);
      wait_drain();
      check("rnd_count", n_hs - h0, (len < DEPTH) ? len : DEPTH);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
